// File: rtl/jpeg_seq_ctrl.sv
// jpeg_seq_ctrl: block sequencer for the dct -> quant -> dequant -> idct
// round-trip datapath. Accepts a block, clears the stages, latches the
// quality setting, walks the cumulative stage enables on each stage's done,
// then pulses out_valid. Repeats for num_blocks blocks per run.
// Optional feature macro: STAGE_TIMEOUT_EN adds a per-stage watchdog that
// aborts to ERR and sets a sticky err flag.
module jpeg_seq_ctrl #(
   parameter int TIMEOUT = 1023,
   parameter int BLK_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BLK_W-1:0] num_blocks,
   input  logic [6:0]       sw,
   input  logic             blk_valid,
   output logic             blk_ready,
   output logic [6:0]       q_sw,
   output logic             stage_rst,
   output logic             dct_en,
   output logic             quant_en,
   output logic             dequant_en,
   output logic             idct_en,
   input  logic             dct_done,
   input  logic             quant_done,
   input  logic             dequant_done,
   input  logic             idct_done,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [BLK_W-1:0] blk_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_LOAD, S_DCT, S_QNT, S_DEQ, S_IDCT, S_EMIT, S_FIN, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [BLK_W-1:0] n_q, n_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [6:0]       q_sw_q, q_sw_d;
   logic             wd_expire;

`ifdef STAGE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            in_stage;

   // Watchdog: restarts on every state change, counts while parked in a stage
   always_comb begin
      in_stage  = (state_q == S_DCT) || (state_q == S_QNT) ||
                  (state_q == S_DEQ) || (state_q == S_IDCT);
      wd_expire = in_stage && (wd_q == WD_LAST);
      wd_d      = '0;
      if (in_stage && (state_d == state_q)) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   // Watchdog and sticky error registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign wd_expire = 1'b0;
   assign err       = 1'b0;
`endif

   // Next-state and decoded outputs; done beats a same-cycle timeout
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      blk_cnt_d  = blk_cnt_q;
      q_sw_d     = q_sw_q;
`ifdef STAGE_TIMEOUT_EN
      err_d      = err_q;
`endif
      blk_ready  = 1'b0;
      stage_rst  = 1'b0;
      dct_en     = 1'b0;
      quant_en   = 1'b0;
      dequant_en = 1'b0;
      idct_en    = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      busy       = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_blocks == '0) begin
                  state_d = S_FIN;
               end else begin
                  n_d       = num_blocks;
                  blk_cnt_d = '0;
`ifdef STAGE_TIMEOUT_EN
                  err_d     = 1'b0;
`endif
                  state_d   = S_CLR;
               end
            end
         end
         S_CLR: begin
            stage_rst = 1'b1;
            state_d   = S_LOAD;
         end
         S_LOAD: begin
            blk_ready = blk_valid;
            if (blk_valid) begin
               q_sw_d  = sw;
               state_d = S_DCT;
            end
         end
         S_DCT: begin
            dct_en = 1'b1;
            if (dct_done) state_d = S_QNT;
            else if (wd_expire) state_d = S_ERR;
         end
         S_QNT: begin
            dct_en   = 1'b1;
            quant_en = 1'b1;
            if (quant_done) state_d = S_DEQ;
            else if (wd_expire) state_d = S_ERR;
         end
         S_DEQ: begin
            dct_en     = 1'b1;
            quant_en   = 1'b1;
            dequant_en = 1'b1;
            if (dequant_done) state_d = S_IDCT;
            else if (wd_expire) state_d = S_ERR;
         end
         S_IDCT: begin
            dct_en     = 1'b1;
            quant_en   = 1'b1;
            dequant_en = 1'b1;
            idct_en    = 1'b1;
            if (idct_done) state_d = S_EMIT;
            else if (wd_expire) state_d = S_ERR;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            state_d   = (blk_cnt_d == n_q) ? S_FIN : S_CLR;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            stage_rst = 1'b1;
`ifdef STAGE_TIMEOUT_EN
            err_d     = 1'b1;
`endif
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, run length, block count and latched quality registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         blk_cnt_q <= '0;
         q_sw_q    <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         blk_cnt_q <= blk_cnt_d;
         q_sw_q    <= q_sw_d;
      end
   end

   assign q_sw    = q_sw_q;
   assign blk_cnt = blk_cnt_q;

endmodule
